// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/write-back for the 16-bit multicycle core
module multicycle_control #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  opcode,
   input  logic        mem_ready,
   input  logic        zero,
   output logic [15:0] reset_pc,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic        i_or_d,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic        ext_sel,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        halted,
   output logic        illegal
);
   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
      WB_ALU, WB_MEM, BRANCH, JUMP, HALT
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LW   = 4'h5;
   localparam logic [3:0] OP_SW   = 4'h6;
   localparam logic [3:0] OP_BEQZ = 4'h7;
   localparam logic [3:0] OP_J    = 4'h8;
   localparam logic [3:0] OP_LUI  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD    = 3'd0;
   localparam logic [2:0] ALU_SUB    = 3'd1;
   localparam logic [2:0] ALU_PASS_B = 3'd4;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       ext_sel;
      logic       reg_write;
      logic       mem_to_reg;
      logic       halted;
      logic       illegal;
   } ctl_t;

   state_t state, next;
   ctl_t   c;
   logic   unused_zero;

   // the zero flag is combined with pc_write_cond in the datapath, not here
   assign unused_zero = zero;
   assign reset_pc    = RESET_PC;

   // holding reset clears every control line immediately, abandoning any memory access
   assign {pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, i_or_d,
           alu_src_a, alu_src_b, alu_op, ext_sel, reg_write, mem_to_reg,
           halted, illegal} = rst_n ? c : '0;

   // state register, async reset into FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= next;
   end

   // next-state and control decode; Moore except the FETCH write gating and DECODE illegal flag
   always_comb begin
      c    = '0;
      next = state;
      case (state)
         FETCH: begin
            c.mem_req   = 1'b1;
            c.alu_src_b = 2'd1;
            c.alu_op    = ALU_ADD;
            c.ir_write  = mem_ready;
            c.pc_write  = mem_ready;
            next        = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            c.alu_src_b = 2'd2;
            c.ext_sel   = 1'b1;
            c.alu_op    = ALU_ADD;
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR: next = EXEC_R;
               OP_ADDI, OP_LUI:               next = EXEC_I;
               OP_LW, OP_SW:                  next = MEM_ADDR;
               OP_BEQZ:                       next = BRANCH;
               OP_J:                          next = JUMP;
               OP_HALT:                       next = HALT;
               default: begin
                  next      = FETCH;
                  c.illegal = 1'b1;
               end
            endcase
         end
         EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = opcode[2:0];
            next        = WB_ALU;
         end
         EXEC_I: begin
            c.alu_src_a = opcode != OP_LUI;
            c.alu_src_b = opcode == OP_LUI ? 2'd3 : 2'd2;
            c.ext_sel   = opcode != OP_LUI;
            c.alu_op    = opcode == OP_LUI ? ALU_PASS_B : ALU_ADD;
            next        = WB_ALU;
         end
         MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            c.ext_sel   = 1'b1;
            c.alu_op    = ALU_ADD;
            next        = opcode == OP_LW ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            c.mem_req = 1'b1;
            c.i_or_d  = 1'b1;
            next      = mem_ready ? WB_MEM : MEM_RD;
         end
         MEM_WR: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.i_or_d  = 1'b1;
            next      = mem_ready ? FETCH : MEM_WR;
         end
         WB_ALU: begin
            c.reg_write = 1'b1;
            next        = FETCH;
         end
         WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            next         = FETCH;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = 2'd2;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_src        = 2'd1;
            next            = FETCH;
         end
         JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = 2'd2;
            next       = FETCH;
         end
         HALT: begin
            c.halted = 1'b1;
            next     = HALT;
         end
         default: next = FETCH;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams checked cycle-by-cycle through a scoreboard
module tb_multicycle_control;
   localparam logic [15:0] RPC = 16'h1A2C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic        mem_ready = 1'b0;
   logic        zero = 1'b0;
   logic [15:0] reset_pc;
   logic        pc_write, pc_write_cond, ir_write, mem_req, mem_we, i_or_d, alu_src_a;
   logic        ext_sel, reg_write, mem_to_reg, halted, illegal;
   logic [1:0]  pc_src, alu_src_b;
   logic [2:0]  alu_op;

   multicycle_control #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .reset_pc(reset_pc), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
      .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .ext_sel(ext_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pw;
      logic       pwc;
      logic [1:0] ps;
      logic       irw;
      logic       mr;
      logic       we;
      logic       iod;
      logic       asa;
      logic [1:0] asb;
      logic [2:0] op;
      logic       ext;
      logic       rw;
      logic       m2r;
      logic       h;
      logic       ill;
   } vec_t;

   typedef enum {P_FW, P_FD, P_D, P_DI, P_ER, P_ADDI, P_LUI, P_MA, P_MR, P_MW,
                 P_WA, P_WM, P_BR, P_J, P_H} ph_t;

   vec_t  act;
   vec_t  exp_q[$];
   string name_q[$];
   vec_t  mon_e;
   string mon_nm;
   int    n_cmp = 0;
   int    n_bad = 0;

   assign act = {pc_write, pc_write_cond, pc_src, ir_write, mem_req, mem_we, i_or_d,
                 alu_src_a, alu_src_b, alu_op, ext_sel, reg_write, mem_to_reg, halted, illegal};

   // expected control word for one phase of an instruction, straight from the phase description
   function automatic vec_t ph(input ph_t p, input logic [3:0] op);
      vec_t e = '0;
      case (p)
         P_FW:   begin e.mr = 1; e.asb = 1; end
         P_FD:   begin e.mr = 1; e.asb = 1; e.irw = 1; e.pw = 1; end
         P_D:    begin e.asb = 2; e.ext = 1; end
         P_DI:   begin e.asb = 2; e.ext = 1; e.ill = 1; end
         P_ER:   begin e.asa = 1; e.op = (op == 0) ? 3'd0 : (op == 1) ? 3'd1 : (op == 2) ? 3'd2 : 3'd3; end
         P_ADDI: begin e.asa = 1; e.asb = 2; e.ext = 1; end
         P_LUI:  begin e.asb = 3; e.op = 4; end
         P_MA:   begin e.asa = 1; e.asb = 2; e.ext = 1; end
         P_MR:   begin e.mr = 1; e.iod = 1; end
         P_MW:   begin e.mr = 1; e.iod = 1; e.we = 1; end
         P_WA:   begin e.rw = 1; end
         P_WM:   begin e.rw = 1; e.m2r = 1; end
         P_BR:   begin e.asa = 1; e.asb = 2; e.op = 1; e.pwc = 1; e.ps = 1; end
         P_J:    begin e.pw = 1; e.ps = 2; end
         P_H:    begin e.h = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // monitor: every cycle the DUT presents a control word, compare it to the oldest expectation
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         mon_e  = exp_q.pop_front();
         mon_nm = name_q.pop_front();
         n_cmp++;
         if (act !== mon_e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", mon_nm, $time, act, mon_e);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
      end
   endtask

   task automatic step(input logic [3:0] op, input logic rdy, input ph_t p, input logic [3:0] iop);
      opcode    = op;
      mem_ready = rdy;
      zero      = 1'($urandom);
      exp_q.push_back(ph(p, iop));
      name_q.push_back(p.name());
      @(posedge clk);
      #1;
   endtask

   // reference sequencing: phases an instruction walks through given its opcode and wait counts
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw);
      for (int i = 0; i < fw; i++) step(4'($urandom), 1'b0, P_FW, op);
      step(4'($urandom), 1'b1, P_FD, op);
      step(op, 1'($urandom), (op >= 4'hA && op <= 4'hE) ? P_DI : P_D, op);
      if (op <= 4'h3) begin
         step(op, 1'($urandom), P_ER, op);
         step(op, 1'($urandom), P_WA, op);
      end else if (op == 4'h4 || op == 4'h9) begin
         step(op, 1'($urandom), op == 4'h4 ? P_ADDI : P_LUI, op);
         step(op, 1'($urandom), P_WA, op);
      end else if (op == 4'h5 || op == 4'h6) begin
         step(op, 1'($urandom), P_MA, op);
         for (int i = 0; i < mw; i++) step(op, 1'b0, op == 4'h5 ? P_MR : P_MW, op);
         step(op, 1'b1, op == 4'h5 ? P_MR : P_MW, op);
         if (op == 4'h5) step(op, 1'($urandom), P_WM, op);
      end else if (op == 4'h7) begin
         step(op, 1'($urandom), P_BR, op);
      end else if (op == 4'h8) begin
         step(op, 1'($urandom), P_J, op);
      end else if (op == 4'hF) begin
         for (int i = 0; i < 20; i++) step(op, 1'(i), P_H, op);
      end
   endtask

   initial begin
      #13;
      check("reset_outputs", 32'(act), 32'h0);
      check("reset_pc", 32'(reset_pc), 32'(RPC));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_instr(4'h0, 0, 0);
      run_instr(4'h5, 2, 2);
      run_instr(4'h7, 0, 0);
      run_instr(4'hB, 1, 0);
      run_instr(4'h6, 0, 1);
      run_instr(4'h8, 1, 0);
      run_instr(4'h9, 0, 0);
      run_instr(4'h4, 2, 0);
      for (int i = 0; i < 80; i++)
         run_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step(4'h0, 1'b0, P_FW, 4'h0);
      step(4'h0, 1'b0, P_FW, 4'h0);
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("reset_mid_fetch", 32'(act), 32'h0);
      check("reset_mid_fetch_pc", 32'(reset_pc), 32'(RPC));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("fetch_after_reset", 32'(act), 32'(ph(P_FW, 4'h0)));
      run_instr(4'h1, 0, 0);
      run_instr(4'hF, int'($urandom_range(0, 3)), 0);
      check("halt_scoreboard_drained", 32'(exp_q.size()), 32'h0);
      rst_n = 1'b0;
      #1;
      check("halt_cleared_by_reset", 32'(act), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_instr(4'h2, 1, 0);
      run_instr(4'h5, 0, 0);
      @(posedge clk);
      #1;
      check("final_scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the 16-bit processor. It sequences fetch, decode, execute, memory and write-back over the shared ALU, register file, sign extender and single unified memory port. It decodes the opcode latched in the instruction register and drives every datapath select, write-enable and memory request. The sign extender's 8-bit immediate feeds the ALU B-input whenever `ext_sel` selects it.

## Interface
- `RESET_PC`, default 16'h0000: value the datapath loads into PC on reset (passed through on `reset_pc`).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: IR[15:12], valid from the cycle after `ir_write`.
- `mem_ready` in 1: memory done; sampled only while `mem_req`=1.
- `zero` in 1: ALU zero flag.
- `reset_pc` out 16: constant `RESET_PC`.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if `zero`. The datapath does the AND.
- `pc_src` out 2: 0=ALU result, 1=ALUOut (branch target), 2=jump target {PC[15:12],IR[11:0]}.
- `ir_write` out 1: latch memory data into IR.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, only with `mem_req`.
- `i_or_d` out 1: 0=PC address, 1=ALUOut address.
- `alu_src_a` out 1: 0=PC, 1=reg A.
- `alu_src_b` out 2: 0=reg B, 1=constant 1, 2=sign-extended imm8, 3=imm8<<8.
- `alu_op` out 3: 0=ADD, 1=SUB, 2=AND, 3=OR, 4=PASS_B.
- `ext_sel` out 1: sign extender output routed to the B mux.
- `reg_write` out 1: register file write.
- `mem_to_reg` out 1: write-back source 0=ALUOut, 1=MDR.
- `halted` out 1: core stopped.
- `illegal` out 1: one-cycle pulse on an undefined opcode.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type); 4 ADDI; 5 LW; 6 SW; 7 BEQZ; 8 J; 9 LUI; F HALT. Codes A–E are illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
- **FETCH:** `mem_req`=1, `i_or_d`=0.
  - `mem_ready`=1: `ir_write`=1, `pc_write`=1, PC+1 (A=PC, B=1, ADD, `pc_src`=0), then go to DECODE.
  - Otherwise hold FETCH with all write enables 0.
- **DECODE:** computes the branch target into ALUOut (A=PC, B=sext imm8, ADD). Next state by opcode:
  - 0–3 → EXEC_R.
  - 4, 9 → EXEC_I.
  - 5, 6 → MEM_ADDR.
  - 7 → BRANCH.
  - 8 → JUMP.
  - F → HALT.
  - Illegal → FETCH, with `illegal`=1 for this cycle.
- **EXEC_R:** A=reg, B=reg, `alu_op`=opcode[2:0], then WB_ALU.
- **EXEC_I:**
  - ADDI: A=reg, B=sext, ADD.
  - LUI: B=imm8<<8, PASS_B.
  - Then WB_ALU.
- **MEM_ADDR:** A=reg, B=sext, ADD, then MEM_RD (LW) or MEM_WR (SW).
- **MEM_RD / MEM_WR:** `mem_req`=1, `i_or_d`=1, `mem_we`=1 in MEM_WR only. Hold until `mem_ready`.
  - MEM_RD → WB_MEM.
  - MEM_WR → FETCH.
- **WB_ALU:** `reg_write`=1, `mem_to_reg`=0, then FETCH.
- **WB_MEM:** `reg_write`=1, `mem_to_reg`=1, then FETCH.
- **BRANCH:** A=reg, PASS_A via SUB with B=0 (alu_src_b=2 with ext_sel=0 forces 0), `pc_write_cond`=1, `pc_src`=1, then FETCH.
- **JUMP:** `pc_write`=1, `pc_src`=2, then FETCH.
- **HALT:** `halted`=1, all enables 0, no exit except reset.
- Outputs are Moore, decoded from state, except:
  - FETCH `ir_write` and `pc_write`, which are gated by `mem_ready`.
  - `illegal`, which depends on `opcode`.
- In every state, any output not listed is 0.

## Timing
- Reset:
  - Async assert forces FETCH.
  - All outputs are 0 except `reset_pc`, and except `mem_req`=1 once reset releases (FETCH).
  - Reset during a memory wait abandons the access. `mem_req` drops asynchronously.
- Cycle counts with zero wait states:
  - R-type, ADDI, LUI: 4.
  - LW: 5.
  - SW: 4.
  - BEQZ: 3.
  - J: 3.
  - Illegal: 2.
- Each memory wait cycle adds exactly 1 cycle. `mem_req` and `mem_we` stay stable for the whole wait.
- `mem_ready` while `mem_req`=0 is ignored.
- `opcode` must be stable from DECODE through the last state of the instruction.
- No combinational path runs from `mem_ready` to `mem_req`.

## Test plan
- Reset mid-FETCH wait (`mem_ready`=0, assert `rst_n`=0) → outputs clear at once. After release, FETCH with `mem_req`=1 and `halted`=0.
- ADD (opcode 0), `mem_ready` tied 1 → states FETCH, DECODE, EXEC_R, WB_ALU. `reg_write`=1 only in cycle 4, `alu_op`=0 in cycle 3.
- LW (opcode 5), memory stalls 2 cycles in both FETCH and MEM_RD → 9 cycles total. `ir_write` pulses exactly once, `mem_to_reg`=1 with `reg_write`=1 in the final cycle.
- BEQZ (opcode 7), immediate 8'b11110000 (ext 16'hFFF0) → DECODE shows `alu_src_b`=2, `ext_sel`=1. BRANCH asserts `pc_write_cond`=1, `pc_src`=1, lasting 3 cycles total.
- Opcode 4'hB → `illegal`=1 for one cycle in DECODE, return to FETCH, no `reg_write` or `pc_write` outside FETCH.
- HALT (4'hF) → `halted`=1 from the cycle after DECODE. It holds for 20 cycles with `mem_ready` toggling. It clears only when `rst_n` falls.
